// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller between instruction fetch and
// the register file / ALU pair. Each instruction runs through four phases:
// accept, decode plus operand read, execute, and retire. On retire it either
// writes back a result, resolves a branch, or flags the instruction as illegal.
module alu_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic [4:0]  rf_ra1_o,
  output logic [4:0]  rf_ra2_o,
  input  logic [31:0] rf_rd1_i,
  input  logic [31:0] rf_rd2_i,
  output logic [31:0] alu_i1_o,
  output logic [31:0] alu_i2_o,
  output logic [4:0]  alu_sel_o,
  input  logic [31:0] alu_o_i,
  input  logic        alu_zero_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        br_valid_o,
  output logic        br_taken_o,
  output logic [31:0] br_offset_o,
  output logic        illegal_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RETIRE} state_t;
  typedef enum logic [1:0] {CLS_WB, CLS_BR, CLS_ILL} cls_t;

  localparam logic [4:0] SEL_ROLV = 5'd0;
  localparam logic [4:0] SEL_RORV = 5'd1;
  localparam logic [4:0] SEL_NOT  = 5'd2;
  localparam logic [4:0] SEL_NORI = 5'd7;
  localparam logic [4:0] SEL_ADD  = 5'd16;
  localparam logic [4:0] SEL_NOR  = 5'd19;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_NORI  = 6'h0E;
  localparam logic [5:0] OP_BLEU  = 6'h1C;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_ROLV = 6'h1C;
  localparam logic [5:0] FN_RORV = 6'h1D;
  localparam logic [5:0] FN_NOT  = 6'h1E;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  cls_t        cls_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_i1_q, alu_i2_q;
  logic [4:0]  alu_sel_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        br_taken_q;
  logic [31:0] br_offset_q;

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext;
  cls_t        dec_cls;
  logic [4:0]  dec_sel, dec_dest;
  logic [31:0] dec_i1, dec_i2;

  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {16'h0000, instr_q[15:0]};

  // Decode the latched instruction into class, selector, operands and destination
  always_comb begin
    dec_cls  = CLS_ILL;
    dec_sel  = SEL_ADD;
    dec_i1   = rf_rd1_i;
    dec_i2   = rf_rd2_i;
    dec_dest = instr_q[15:11];
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin dec_cls = CLS_WB; dec_sel = SEL_ADD; end
          FN_NOR:  begin dec_cls = CLS_WB; dec_sel = SEL_NOR; end
          FN_ROLV: begin dec_cls = CLS_WB; dec_sel = SEL_ROLV; dec_i1 = {29'd0, rf_rd1_i[2:0]}; end
          FN_RORV: begin dec_cls = CLS_WB; dec_sel = SEL_RORV; dec_i1 = {29'd0, rf_rd1_i[2:0]}; end
          FN_NOT:  begin dec_cls = CLS_WB; dec_sel = SEL_NOT;  dec_i2 = 32'd0; end
          default: dec_cls = CLS_ILL;
        endcase
      end
      OP_ADDI: begin
        dec_cls  = CLS_WB;
        dec_sel  = SEL_ADD;
        dec_i2   = imm_sext;
        dec_dest = instr_q[20:16];
      end
      OP_NORI: begin
        dec_cls  = CLS_WB;
        dec_sel  = SEL_NORI;
        dec_i2   = imm_zext;
        dec_dest = instr_q[20:16];
      end
      OP_BLEU: begin
        dec_cls = CLS_BR;
        dec_sel = SEL_ADD;
      end
      default: dec_cls = CLS_ILL;
    endcase
  end

  // Phase sequencing; illegal instructions skip the execute phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid_i) state_d = DECODE;
      DECODE:  state_d = (dec_cls == CLS_ILL) ? RETIRE : EXEC;
      EXEC:    state_d = RETIRE;
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, instruction latch, ALU operand registers and retire result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      instr_q     <= 32'd0;
      cls_q       <= CLS_WB;
      dest_q      <= 5'd0;
      alu_i1_q    <= 32'd0;
      alu_i2_q    <= 32'd0;
      alu_sel_q   <= SEL_ADD;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      br_taken_q  <= 1'b0;
      br_offset_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid_i) begin
        instr_q <= instr_i;
      end
      if (state_q == DECODE) begin
        cls_q  <= dec_cls;
        dest_q <= dec_dest;
        if (dec_cls != CLS_ILL) begin
          alu_i1_q  <= dec_i1;
          alu_i2_q  <= dec_i2;
          alu_sel_q <= dec_sel;
        end
      end
      if (state_q == EXEC) begin
        if (cls_q == CLS_WB && dest_q != 5'd0) begin
          wb_addr_q <= dest_q;
          wb_data_q <= alu_o_i;
        end
        if (cls_q == CLS_BR) begin
          br_taken_q  <= alu_zero_i;
          br_offset_q <= {imm_sext[29:0], 2'b00};
        end
      end
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign rf_ra1_o      = instr_q[25:21];
  assign rf_ra2_o      = instr_q[20:16];
  assign alu_i1_o      = alu_i1_q;
  assign alu_i2_o      = alu_i2_q;
  assign alu_sel_o     = alu_sel_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign br_taken_o    = br_taken_q;
  assign br_offset_o   = br_offset_q;
  assign done_o        = (state_q == RETIRE);
  assign wb_en_o       = (state_q == RETIRE) && (cls_q == CLS_WB) && (dest_q != 5'd0);
  assign br_valid_o    = (state_q == RETIRE) && (cls_q == CLS_BR);
  assign illegal_o     = (state_q == RETIRE) && (cls_q == CLS_ILL);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a register file and ALU live in the bench, and
// a per-cycle expectation table is filled from instruction-level semantics.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] alu_i1, alu_i2, alu_o;
  logic [4:0]  alu_sel;
  logic        alu_zero;
  logic        wb_en, br_valid, br_taken, illegal, done;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, br_offset;

  logic [31:0] regs [32];

  typedef struct {
    bit          isReset;
    bit          hasAlu;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [4:0]  sel;
    bit          wb;
    bit          br;
    bit          ill;
    bit          done;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          tk;
    logic [31:0] off;
  } exp_t;

  exp_t expAt [int];
  exp_t cur;
  int   cyc = 0;
  int   readyFrom = 0;
  bit   checkOn = 1'b0;
  int   nTests = 0;
  int   nFail = 0;
  int   numDriven = 0;
  int   hsEdges [$];

  alu_issue_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_i(instr), .instr_ready_o(instr_ready),
    .rf_ra1_o(rf_ra1), .rf_ra2_o(rf_ra2), .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2),
    .alu_i1_o(alu_i1), .alu_i2_o(alu_i2), .alu_sel_o(alu_sel),
    .alu_o_i(alu_o), .alu_zero_i(alu_zero),
    .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .br_valid_o(br_valid), .br_taken_o(br_taken), .br_offset_o(br_offset),
    .illegal_o(illegal), .done_o(done)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational register file read ports
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  // Datapath ALU as seen by the controller
  logic [63:0] dbl;
  always_comb begin
    dbl   = {alu_i2, alu_i2};
    alu_o = 32'hDEADBEEF;
    case (alu_sel)
      5'd0:        begin dbl = dbl << alu_i1[4:0]; alu_o = dbl[63:32]; end
      5'd1:        begin dbl = dbl >> alu_i1[4:0]; alu_o = dbl[31:0]; end
      5'd2:        alu_o = ~alu_i1;
      5'd7, 5'd19: alu_o = ~(alu_i1 | alu_i2);
      5'd16:       alu_o = alu_i1 + alu_i2;
      default:     alu_o = 32'hDEADBEEF;
    endcase
    alu_zero = ($signed(alu_i2) >= $signed(alu_i1));
  end

  // Record the edge number of every accepted instruction
  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) hsEdges.push_back(cyc + 1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every cycle against the expectation table; strobes default to 0
  always @(negedge clk) begin
    if (checkOn) begin
      cur = '{default: '0};
      if (expAt.exists(cyc)) cur = expAt[cyc];
      checkOutput("instr_ready", instr_ready, (cyc >= readyFrom));
      checkOutput("wb_en", wb_en, cur.wb);
      checkOutput("br_valid", br_valid, cur.br);
      checkOutput("illegal", illegal, cur.ill);
      checkOutput("done", done, cur.done);
      if (cur.wb) begin
        checkOutput("wb_addr", wb_addr, cur.wa);
        checkOutput("wb_data", wb_data, cur.wd);
      end
      if (cur.br) begin
        checkOutput("br_taken", br_taken, cur.tk);
        checkOutput("br_offset", br_offset, cur.off);
      end
      if (cur.hasAlu) begin
        checkOutput("alu_i1", alu_i1, cur.i1);
        checkOutput("alu_i2", alu_i2, cur.i2);
        checkOutput("alu_sel", alu_sel, cur.sel);
      end
      if (cur.isReset) begin
        checkOutput("rst_alu_i1", alu_i1, 32'd0);
        checkOutput("rst_alu_i2", alu_i2, 32'd0);
        checkOutput("rst_alu_sel", alu_sel, 32'd16);
        checkOutput("rst_wb_addr", wb_addr, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_br_offset", br_offset, 32'd0);
        checkOutput("rst_br_taken", br_taken, 32'd0);
        checkOutput("rst_rf_ra1", rf_ra1, 32'd0);
        checkOutput("rst_rf_ra2", rf_ra2, 32'd0);
      end
    end
  end

  // Instruction semantics: expected EXEC-cycle operands and RETIRE outcome
  task automatic predict(input logic [31:0] ins, output exp_t exA, output exp_t exR, output bit isIll);
    logic [5:0]  op, fn;
    logic [31:0] a, b, sx, zx, res;
    logic [4:0]  dest;
    int          n;
    bit          isBr;
    op = ins[31:26]; fn = ins[5:0];
    a = regs[ins[25:21]]; b = regs[ins[20:16]];
    sx = {{16{ins[15]}}, ins[15:0]}; zx = {16'h0, ins[15:0]};
    n = int'(a[2:0]);
    dest = ins[15:11]; res = 32'd0; isBr = 1'b0; isIll = 1'b0;
    exA = '{default: '0}; exR = '{default: '0};
    exA.hasAlu = 1'b1; exA.i1 = a; exA.i2 = b; exA.sel = 5'd16;
    if (op == 6'h00) begin
      case (fn)
        6'h20: res = a + b;
        6'h27: begin exA.sel = 5'd19; res = ~(a | b); end
        6'h1C: begin exA.sel = 5'd0; exA.i1 = {29'd0, a[2:0]}; res = (b << n) | (b >> (32 - n)); end
        6'h1D: begin exA.sel = 5'd1; exA.i1 = {29'd0, a[2:0]}; res = (b >> n) | (b << (32 - n)); end
        6'h1E: begin exA.sel = 5'd2; exA.i2 = 32'd0; res = ~a; end
        default: isIll = 1'b1;
      endcase
    end else if (op == 6'h08) begin
      exA.i2 = sx; res = a + sx; dest = ins[20:16];
    end else if (op == 6'h0E) begin
      exA.sel = 5'd7; exA.i2 = zx; res = ~(a | zx); dest = ins[20:16];
    end else if (op == 6'h1C) begin
      isBr = 1'b1;
    end else begin
      isIll = 1'b1;
    end
    exR.done = 1'b1;
    if (isIll) exR.ill = 1'b1;
    else if (isBr) begin
      exR.br = 1'b1; exR.tk = ($signed(b) >= $signed(a)); exR.off = sx << 2;
    end else if (dest != 5'd0) begin
      exR.wb = 1'b1; exR.wa = dest; exR.wd = res;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int budget = 0;
    while (cyc < readyFrom && budget < 50) begin tick(); budget++; end
    if (cyc < readyFrom) begin
      nTests++; nFail++;
      $display("[TB] FAIL idle_wait: still busy at cycle %0d, idle expected from %0d", cyc, readyFrom);
    end
  endtask

  task automatic randomizeRegs();
    for (int i = 1; i < 32; i++)
      regs[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    regs[0] = 32'd0;
  endtask

  // Offer one instruction on an IDLE cycle; returns once its operands were read
  task automatic applyStimulus(input logic [31:0] ins, input bit hold, input bit doRand);
    exp_t exA, exR;
    bit   ill;
    int   n;
    waitIdle();
    if (doRand) randomizeRegs();
    predict(ins, exA, exR, ill);
    instr = ins; instr_valid = 1'b1;
    n = cyc + 1;
    if (ill) begin
      expAt[n + 1] = exR; readyFrom = n + 2;
    end else begin
      expAt[n + 1] = exA; expAt[n + 2] = exR; readyFrom = n + 3;
    end
    numDriven++;
    tick();
    if (!hold) instr_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int          k;
    logic [5:0]  op;
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    r[15:11] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    case (k)
      0: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
      1: begin r[31:26] = 6'h00; r[5:0] = 6'h27; end
      2: begin r[31:26] = 6'h00; r[5:0] = 6'h1C; end
      3: begin r[31:26] = 6'h00; r[5:0] = 6'h1D; end
      4: begin r[31:26] = 6'h00; r[5:0] = 6'h1E; end
      5: r[31:26] = 6'h08;
      6: r[31:26] = 6'h0E;
      7: r[31:26] = 6'h1C;
      8: begin
        op = 6'($urandom);
        if (op == 6'h00 || op == 6'h08 || op == 6'h0E || op == 6'h1C) op = 6'h3F;
        r[31:26] = op;
      end
      default: r[31:26] = 6'h00;
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t rstExp;
    bit   prevHold;
    int   base, n;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rstExp = '{default: '0};
    rstExp.isReset = 1'b1;

    tick(); tick(); tick();
    expAt[cyc + 1] = rstExp;
    readyFrom = 0;
    checkOn = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // rolv r4 <- rotl(r2, r1[2:0])
    regs[1] = 32'd3; regs[2] = 32'h80000001;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h1C}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_rolv_wb_data", wb_data, 32'h0000000C);
    checkOutput("pin_rolv_wb_addr", wb_addr, 32'd4);

    regs[1] = 32'd1; regs[2] = 32'h00000001;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h1D}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_rorv_wb_data", wb_data, 32'h80000000);

    regs[1] = 32'h0F0F0F0F; regs[2] = 32'h00FF00FF;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h27}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_nor_wb_data", wb_data, 32'hF000F000);

    regs[1] = 32'd5;
    applyStimulus({6'h08, 5'd1, 5'd5, 16'hFFFF}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_addi_alu_i2", alu_i2, 32'hFFFFFFFF);
    checkOutput("pin_addi_wb_data", wb_data, 32'd4);
    checkOutput("pin_addi_wb_addr", wb_addr, 32'd5);

    regs[1] = 32'h0000F000;
    applyStimulus({6'h0E, 5'd1, 5'd6, 16'h00FF}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_nori_alu_i2", alu_i2, 32'h000000FF);
    checkOutput("pin_nori_wb_data", wb_data, 32'hFFFF0F00);

    regs[1] = 32'd2; regs[2] = 32'd5;
    applyStimulus({6'h1C, 5'd1, 5'd2, 16'h0004}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_bleu_taken", br_taken, 32'd1);
    checkOutput("pin_bleu_offset", br_offset, 32'h00000010);

    regs[1] = 32'd7;
    applyStimulus({6'h1C, 5'd1, 5'd2, 16'h0004}, 1'b0, 1'b0);
    waitIdle();
    checkOutput("pin_bleu_not_taken", br_taken, 32'd0);

    applyStimulus({6'h3F, 26'd0}, 1'b0, 1'b0);
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 1'b0, 1'b0);

    // Back-to-back with valid held high
    base = hsEdges.size();
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b1, 1'b1);
    applyStimulus({6'h08, 5'd2, 5'd3, 16'h8001}, 1'b1, 1'b1);
    applyStimulus({6'h00, 5'd3, 5'd1, 5'd2, 5'd0, 6'h27}, 1'b1, 1'b1);
    instr_valid = 1'b0;
    waitIdle();
    for (int i = base + 1; i < hsEdges.size(); i++)
      checkOutput("hs_spacing", 32'(hsEdges[i] - hsEdges[i - 1]), 32'd4);

    // Reset while in EXEC discards the instruction
    regs[1] = 32'd9; regs[2] = 32'd1;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 1'b0, 1'b0);
    n = cyc;
    rst_n = 1'b0;
    expAt[n + 1] = rstExp;
    readyFrom = n + 1;
    tick();
    rst_n = 1'b1;
    tick();

    // Handshake coinciding with reset is ignored
    waitIdle();
    instr = {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20};
    instr_valid = 1'b1;
    rst_n = 1'b0;
    expAt[cyc + 1] = rstExp;
    tick();
    rst_n = 1'b1;
    instr_valid = 1'b0;
    tick(); tick(); tick(); tick();

    // Randomized traffic with idle gaps and held-valid runs
    prevHold = 1'b0;
    for (int t = 0; t < 200; t++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0);
      if (!prevHold) begin
        waitIdle();
        repeat ($urandom_range(0, 2)) tick();
      end
      applyStimulus(randInstr(), hold, 1'b1);
      prevHold = hold;
    end
    instr_valid = 1'b0;
    waitIdle();
    tick(); tick();
    checkOutput("hs_count", 32'(hsEdges.size()), 32'(numDriven));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that drives the datapath ALU from the instruction side. It accepts one 32-bit instruction per valid/ready handshake and decodes it into the 5-bit ALU selector. It then fetches operands from the register file, presents them to the ALU, captures the result and `zero` flag, and finishes with either a register writeback or a branch decision. It sits between instruction fetch and the register file/ALU pair in the multi-cycle core.

## Interface
- No parameters; data width fixed at 32, register address 5, selector 5.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: instruction offered.
- `instr` in 32: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
- `instr_ready` out 1: high only in IDLE.
- `rf_ra1`, `rf_ra2` out 5: register read addresses (rs, rt).
- `rf_rd1`, `rf_rd2` in 32: combinational read data for `rf_ra1`/`rf_ra2`.
- `alu_i1`, `alu_i2` out 32: ALU operands (registered).
- `alu_sel` out 5: ALU selector (registered).
- `alu_o` in 32: ALU result. `alu_zero` in 1: ALU flag; 1 when rt−rs ≥ 0 (signed).
- `wb_en` out 1: one-cycle writeback strobe. `wb_addr` out 5. `wb_data` out 32.
- `br_valid` out 1: one-cycle branch-resolved strobe. `br_taken` out 1. `br_offset` out 32.
- `illegal` out 1: one-cycle strobe for an undecodable instruction.
- `done` out 1: one-cycle strobe when any instruction retires, illegal included.

## Operation
- Decode. Selector codes: rolv=0, rorv=1, not=2, nori=7, add=16, nor=19.
  - opcode 0x00 with funct 0x20: add. I1=rs, I2=rt, dest rd.
  - opcode 0x00 with funct 0x27: nor. I1=rs, I2=rt, dest rd.
  - opcode 0x00 with funct 0x1C: rolv. I1=rs (amount, bits [2:0] only), I2=rt, dest rd.
  - opcode 0x00 with funct 0x1D: rorv. Operands and dest as rolv.
  - opcode 0x00 with funct 0x1E: not. I1=rs, I2=0, dest rd.
  - opcode 0x08: addi (sel 16). I1=rs, I2=sign-extended imm, dest rt.
  - opcode 0x0E: nori (sel 7). I1=rs, I2=zero-extended imm, dest rt.
  - opcode 0x1C: bleu (sel 16). I1=rs, I2=rt, no dest. Taken iff `alu_zero`=1. `br_offset` = sign-extended imm << 2.
  - Any other opcode/funct combination is illegal.
- FSM states and transitions:
  - IDLE → DECODE on `instr_valid && instr_ready`; the instruction is latched.
  - DECODE: drive `rf_ra1`=rs and `rf_ra2`=rt. Latch `rf_rd1`/`rf_rd2`, the decoded selector, dest and class.
    - Illegal instructions go directly to RETIRE with no ALU access.
    - Otherwise → EXEC.
  - EXEC: `alu_i1`/`alu_i2`/`alu_sel` are valid this cycle. Latch `alu_o` and `alu_zero` at the cycle end. → RETIRE.
  - RETIRE: exactly one of the following, then → IDLE.
    - `wb_en`=1 with `wb_addr`/`wb_data`.
    - `br_valid`=1 with `br_taken`.
    - `illegal`=1.
    - In every case `done`=1.
- Writes with a destination of $0 are suppressed: `wb_en` stays 0, `done` still pulses.
- Outputs hold their last values between strobes, except the strobes themselves, which are 0 outside RETIRE.
- All arithmetic is 32-bit and wraps modulo 2^32. No overflow trap.

## Timing
- Reset values:
  - State IDLE; `instr_ready`=1.
  - All strobes (`wb_en`, `br_valid`, `illegal`, `done`) = 0; `br_taken`=0.
  - `alu_i1`, `alu_i2`, `wb_data`, `br_offset` = 0; `alu_sel`=16; `rf_ra*`=0; `wb_addr`=0.
- Latency:
  - Handshake at edge N; DECODE in cycle N+1, EXEC in N+2, RETIRE strobes in N+3.
  - Illegal instructions retire in N+2.
- Throughput is at most one instruction per 4 cycles (3 for illegal). `instr_ready` is 0 in DECODE, EXEC and RETIRE.
- If `instr_valid` is held high through RETIRE, the next instruction is accepted on the first IDLE cycle. No instruction is dropped or accepted twice.
- `rst_n`=0 at any edge forces IDLE and reset values on that edge:
  - An in-flight instruction is discarded with no `wb_en`, `br_valid` or `done`.
  - A handshake on the same edge as reset is ignored.

## Test plan
- rolv: r1=3, r2=0x80000001, instr rd=r4 → sel 0 in EXEC. RETIRE: `wb_en`=1, `wb_addr`=4, `wb_data`=0x0000000C, 3 cycles after handshake.
- rorv: r1=1, r2=0x00000001 → `wb_data`=0x80000000. nor: r1=0x0F0F0F0F, r2=0x00FF00FF → `wb_data`=0xF000F000.
- addi r5 ← r1 + 0xFFFF with r1=5 → `alu_i2`=0xFFFFFFFF, `wb_data`=4. nori with imm 0x00FF, r1=0x0000F000 → `alu_i2`=0x000000FF, `wb_data`=0xFFFF0F00.
- bleu with imm 0x0004:
  - rs=2, rt=5 → `br_valid`=1, `br_taken`=1, `br_offset`=0x10, `wb_en`=0.
  - rs=7, rt=5 → `br_taken`=0.
- Illegal opcode 0x3F → `illegal`=1 and `done`=1 two cycles after handshake, no `wb_en`. Write to $0 via add → `done`=1, `wb_en`=0.
- Reset in EXEC:
  - `rst_n`=0 one cycle → no strobes, `instr_ready`=1 next cycle.
  - Back-to-back `instr_valid` held high → handshakes exactly 4 cycles apart.
